// File: rtl/program_memory_loadable.sv
// program_memory_loadable
// Instruction memory for the single-cycle RISC CPU, filled at run time over a
// byte-serial boot-load stream. Bytes are assembled MSB-first into words and the
// image is closed by a single checksum byte: the 8-bit sum of every byte,
// checksum included, must be zero. Until a verified image is present the CPU is
// held and the fetch port presents HALT_WORD.
// INSTR_W must be a multiple of 8 and at least 16.

module program_memory_loadable #(
  parameter int                 INSTR_W   = 32,
  parameter int                 DEPTH     = 4096,
  parameter int                 ADDR_W    = 12,
  parameter logic [INSTR_W-1:0] HALT_WORD = 32'hFF000000
) (
  input  logic               clk_70_mhz,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  program_addr,
  output logic [INSTR_W-1:0] instruction,
  input  logic               load_start,
  input  logic [ADDR_W:0]    load_len,
  input  logic [7:0]         load_byte,
  input  logic               load_valid,
  output logic               load_ready,
  output logic               load_busy,
  output logic               load_done,
  output logic               load_err,
  output logic [ADDR_W:0]    load_count,
  output logic               cpu_hold
);

  localparam int BPW     = INSTR_W / 8;
  localparam int BIDX_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int SHIFT_W = INSTR_W - 8;

  localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W+1)'(DEPTH);
  localparam logic [BIDX_W-1:0] LAST_BIDX  = BIDX_W'(BPW - 1);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [BIDX_W-1:0] BIDX_ONE   = BIDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Running mod-256 checksum of the image stream.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    csum_add = acc + b;
  endfunction

  state_t              r_state;
  logic                r_program_valid;
  logic                r_load_ready;
  logic                r_load_busy;
  logic                r_load_done;
  logic                r_load_err;
  logic                r_cpu_hold;
  logic [ADDR_W:0]     r_load_count;
  logic [ADDR_W:0]     r_len;
  logic [BIDX_W-1:0]   r_byte_idx;
  logic [7:0]          r_csum;
  logic [SHIFT_W-1:0]  r_shift;

  logic [INSTR_W-1:0]  r_mem [DEPTH];

  logic                w_accept;
  logic                w_last_byte;
  logic                w_mem_we;
  logic [INSTR_W-1:0]  w_word;
  logic [7:0]          w_csum_next;
  logic [ADDR_W:0]     w_count_inc;
  logic                w_addr_oob;

  assign w_accept    = load_valid & r_load_ready;
  assign w_last_byte = (r_byte_idx == LAST_BIDX);
  assign w_word      = {r_shift, load_byte};
  assign w_csum_next = csum_add(r_csum, load_byte);
  assign w_count_inc = r_load_count + COUNT_ONE;
  // The count guard keeps a write from ever landing past the latched length.
  assign w_mem_we    = (r_state == ST_RECV) & w_accept & w_last_byte & (r_load_count < r_len);
  assign w_addr_oob  = ({1'b0, program_addr} >= DEPTH_L);

  assign load_ready  = r_load_ready;
  assign load_busy   = r_load_busy;
  assign load_done   = r_load_done;
  assign load_err    = r_load_err;
  assign load_count  = r_load_count;
  assign cpu_hold    = r_cpu_hold;

  // Fetch path: HALT_WORD while held or out of range, otherwise the stored word.
  always_comb begin
    instruction = HALT_WORD;
    if (r_cpu_hold || w_addr_oob) begin
      instruction = HALT_WORD;
    end else begin
      instruction = r_mem[program_addr];
    end
  end

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge clk_70_mhz) begin
    if (w_mem_we) begin
      r_mem[r_load_count[ADDR_W-1:0]] <= w_word;
    end
  end

  // Load FSM: length check, byte assembly, word count, checksum verdict.
  // cpu_hold is kept as a register equal to load_busy | ~program_valid by
  // updating it on every transition that changes either term.
  always_ff @(posedge clk_70_mhz) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_program_valid <= 1'b0;
      r_load_ready    <= 1'b0;
      r_load_busy     <= 1'b0;
      r_load_done     <= 1'b0;
      r_load_err      <= 1'b0;
      r_cpu_hold      <= 1'b1;
      r_load_count    <= '0;
      r_len           <= '0;
      r_byte_idx      <= '0;
      r_csum          <= 8'h00;
      r_shift         <= '0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_load_ready <= 1'b0;
          r_load_busy  <= 1'b0;
          if (load_start) begin
            r_program_valid <= 1'b0;
            r_cpu_hold      <= 1'b1;
            r_load_count    <= '0;
            r_byte_idx      <= '0;
            r_csum          <= 8'h00;
            r_shift         <= '0;
            r_len           <= load_len;
            if ((load_len == '0) || (load_len > DEPTH_L)) begin
              r_load_err  <= 1'b1;
              r_load_done <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_load_err   <= 1'b0;
              r_load_ready <= 1'b1;
              r_load_busy  <= 1'b1;
              r_state      <= ST_RECV;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_RECV: begin
          if (w_accept) begin
            r_csum <= w_csum_next;
            if (w_last_byte) begin
              r_byte_idx <= '0;
              r_shift    <= '0;
              if (r_load_count < r_len) begin
                r_load_count <= w_count_inc;
              end else begin
                r_load_count <= r_len;
              end
              if (w_count_inc >= r_len) begin
                r_state <= ST_CHECK;
              end else begin
                r_state <= ST_RECV;
              end
            end else begin
              r_byte_idx <= r_byte_idx + BIDX_ONE;
              r_shift    <= w_word[SHIFT_W-1:0];
              r_state    <= ST_RECV;
            end
          end else begin
            r_state <= ST_RECV;
          end
        end

        ST_CHECK: begin
          if (w_accept) begin
            r_csum          <= w_csum_next;
            r_load_err      <= (w_csum_next != 8'h00);
            r_program_valid <= (w_csum_next == 8'h00);
            r_cpu_hold      <= (w_csum_next != 8'h00);
            r_load_ready    <= 1'b0;
            r_load_busy     <= 1'b0;
            r_load_done     <= 1'b1;
            r_state         <= ST_DONE;
          end else begin
            r_state <= ST_CHECK;
          end
        end

        ST_DONE: begin
          r_load_ready <= 1'b0;
          r_load_busy  <= 1'b0;
          r_state      <= ST_IDLE;
        end

        default: begin
          r_load_ready    <= 1'b0;
          r_load_busy     <= 1'b0;
          r_program_valid <= 1'b0;
          r_cpu_hold      <= 1'b1;
          r_state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_memory_loadable.sv
// Bench for program_memory_loadable: directed boot-load scenarios. Each load
// that should end in a load_done pulse pushes its expected result into a queue;
// a monitor pops and compares on every load_done it observes.

module tb_program_memory_loadable;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic              err;
    logic [ADDR_W:0]   count;
    logic              hold;
  } exp_t;

  logic               clk_70_mhz = 1'b0;
  logic               reset;
  logic [ADDR_W-1:0]  program_addr;
  logic [INSTR_W-1:0] instruction;
  logic               load_start;
  logic [ADDR_W:0]    load_len;
  logic [7:0]         load_byte;
  logic               load_valid;
  logic               load_ready;
  logic               load_busy;
  logic               load_done;
  logic               load_err;
  logic [ADDR_W:0]    load_count;
  logic               cpu_hold;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  logic [7:0]  img [16];
  logic [31:0] words [4];

  program_memory_loadable dut (
    .clk_70_mhz  (clk_70_mhz),
    .reset       (reset),
    .program_addr(program_addr),
    .instruction (instruction),
    .load_start  (load_start),
    .load_len    (load_len),
    .load_byte   (load_byte),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_err    (load_err),
    .load_count  (load_count),
    .cpu_hold    (cpu_hold)
  );

  always #7 clk_70_mhz = ~clk_70_mhz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every load_done pulse is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_70_mhz);
      if (load_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(load_done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_err",   32'(load_err),   32'(e.err));
          check("done_count", 32'(load_count), 32'(e.count));
          check("done_hold",  32'(cpu_hold),   32'(e.hold));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_70_mhz);
    #1;
  endtask

  task automatic start_load(input logic [ADDR_W:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick(1);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    load_byte  = b;
    load_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = load_ready;
      tick(1);
    end
    load_valid = 1'b0;
    check("byte_accept", 32'(ok), 32'd1);
  endtask

  // Sends the first nbytes of image+checksum; gap idle cycles before each byte;
  // poke pulses load_start mid-load (must be ignored).
  task automatic send_image(input logic [7:0] cks, input int nbytes, input int gap, input bit poke);
    for (int i = 0; i < nbytes; i++) begin
      if (gap > 0) begin
        load_valid = 1'b0;
        tick(gap);
      end
      if (poke && i == 6) begin
        start_load(13'd1);
        load_len = 13'd4;
      end
      send_byte((i < 16) ? img[i] : cks);
    end
  endtask

  task automatic check_fetch_image(input string tag);
    for (int a = 0; a < 4; a++) begin
      program_addr = 12'(a);
      #1;
      check(tag, instruction, words[a]);
    end
  endtask

  initial begin
    img = '{8'h03, 8'h00, 8'h00, 8'h03, 8'h03, 8'h10, 8'h00, 8'h0A,
            8'h06, 8'h20, 8'h10, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
    words = '{32'h03000003, 32'h0310000A, 32'h06201000, 32'hFF000000};
    reset        = 1'b1;
    program_addr = '0;
    load_start   = 1'b0;
    load_len     = '0;
    load_byte    = 8'h00;
    load_valid   = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    program_addr = 12'd0;
    #1;
    check("rst_instr0", instruction, 32'hFF000000);
    program_addr = 12'd5;
    #1;
    check("rst_instr5", instruction, 32'hFF000000);
    check("rst_hold",  32'(cpu_hold),   32'd1);
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_busy",  32'(load_busy),  32'd0);
    check("rst_err",   32'(load_err),   32'd0);
    check("rst_count", 32'(load_count), 32'd0);
    check("rst_done",  32'(load_done),  32'd0);

    // Good load
    exp_q.push_back('{err: 1'b0, count: 13'd4, hold: 1'b0});
    start_load(13'd4);
    check("recv_ready", 32'(load_ready), 32'd1);
    check("recv_busy",  32'(load_busy),  32'd1);
    check("recv_hold",  32'(cpu_hold),   32'd1);
    send_image(8'hA8, 17, 0, 1'b0);
    tick(3);
    check("good_hold", 32'(cpu_hold), 32'd0);
    check_fetch_image("good_fetch");

    // Bad checksum
    exp_q.push_back('{err: 1'b1, count: 13'd4, hold: 1'b1});
    start_load(13'd4);
    send_image(8'hA9, 17, 0, 1'b0);
    tick(3);
    program_addr = 12'd0;
    #1;
    check("badck_instr", instruction, 32'hFF000000);
    check("badck_hold",  32'(cpu_hold), 32'd1);
    check("badck_err",   32'(load_err), 32'd1);

    // Gapped load with an ignored load_start mid-stream
    exp_q.push_back('{err: 1'b0, count: 13'd4, hold: 1'b0});
    start_load(13'd4);
    send_image(8'hA8, 17, 2, 1'b1);
    tick(3);
    check_fetch_image("gap_fetch");

    // Bad lengths
    exp_q.push_back('{err: 1'b1, count: 13'd0, hold: 1'b1});
    start_load(13'd0);
    check("len0_done", 32'(load_done), 32'd1);
    tick(3);
    program_addr = 12'd0;
    #1;
    check("len0_instr", instruction, 32'hFF000000);
    exp_q.push_back('{err: 1'b1, count: 13'd0, hold: 1'b1});
    start_load(13'd4097);
    check("len4097_done", 32'(load_done), 32'd1);
    check("len4097_err",  32'(load_err),  32'd1);
    tick(3);

    // Reset after 6 bytes, then a fresh load
    start_load(13'd4);
    send_image(8'hA8, 6, 0, 1'b0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midrst_hold",  32'(cpu_hold),   32'd1);
    check("midrst_count", 32'(load_count), 32'd0);
    check("midrst_busy",  32'(load_busy),  32'd0);
    check("midrst_ready", 32'(load_ready), 32'd0);
    tick(2);
    exp_q.push_back('{err: 1'b0, count: 13'd4, hold: 1'b0});
    start_load(13'd4);
    send_image(8'hA8, 17, 0, 1'b0);
    tick(3);
    check_fetch_image("fresh_fetch");

    check("pending_done", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
